wb_io_arbiter: RTL and testbench
================================

Name: wb_io_arbiter

Overview:
Two-master to one-slave Wishbone arbiter that shares the IO interconnect port between the CPU IO master (m0) and a DMA/secondary master (m1).
- Grants the bus round-robin and holds the grant for the whole of the owner's cyc.
- Forwards the owner's request to the slave port and routes the slave response back to the owner.
- Runs a watchdog that terminates a hung access with err, so an unmapped or dead peripheral cannot lock the IO bus.

Parameters:
TIMEOUT, 255, cycles an owner may hold stb without ack/err/rty before the arbiter forces err; legal range 2..65535.
CNT_W, $clog2(TIMEOUT+1), watchdog counter width; derived, do not override.

Ports:
wb_clk_i  in  1  system clock; all logic rising-edge.
wb_rst_i  in  1  synchronous active-high reset.
wbmN_adr_i, wbmN_dat_i (N=0,1)  in  32 each  master address / write data.
wbmN_sel_i  in  4  byte selects.
wbmN_we_i, wbmN_cyc_i, wbmN_stb_i  in  1 each  write enable, cycle, strobe.
wbmN_cti_i  in  3  cycle type.
wbmN_bte_i  in  2  burst type.
wbmN_dat_o  out  32  read data (wbs_dat_i fanned out to both masters).
wbmN_ack_o, wbmN_err_o, wbmN_rty_o  out  1 each  terminations; asserted to owner only.
wbs_adr_o, wbs_dat_o  out  32 each  to interconnect mux.
wbs_sel_o  out  4  to interconnect mux.
wbs_we_o, wbs_cyc_o, wbs_stb_o  out  1 each  to interconnect mux.
wbs_cti_o  out  3  to interconnect mux.
wbs_bte_o  out  2  to interconnect mux.
wbs_dat_i  in  32  from interconnect mux.
wbs_ack_i, wbs_err_i, wbs_rty_i  in  1 each  from interconnect mux.
owner_o  out  1  current owner index; valid while busy_o=1.
busy_o  out  1  a grant is active.
tout_o  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- State register: IDLE, BUSY, TOUT. Registers: owner, last_owner, wd_cnt[CNT_W-1:0].
- Reset (synchronous, wb_rst_i=1 at a clock edge):
  - state=IDLE, owner=0, last_owner=1, wd_cnt=0.
  - Outputs: busy_o=0, tout_o=0, all wbs_* request outputs 0, all master ack/err/rty 0.
  - Applies mid-transfer: the in-flight access is abandoned with no termination issued.
- IDLE:
  - Only m0 cyc=1: grant m0. Only m1 cyc=1: grant m1.
  - Both cyc=1: grant !last_owner (round-robin; first contention after reset goes to m0).
  - On a grant, the next state is BUSY with owner updated, so grant latency is 1 cycle after cyc is sampled high.
- BUSY:
  - wbs_* request outputs = owner's inputs (combinational mux).
  - Owner's ack/err/rty = wbs_ack_i/err_i/rty_i combinationally, so there is no added latency per beat.
  - Non-owner's ack/err/rty held 0.
  - Owner cyc=0 at a clock edge: next state IDLE and last_owner=owner. Exactly one idle cycle separates grants; no same-cycle regrant.
  - A non-owner's cyc is ignored until the owner releases. Owner bursts (cti=010) are never preempted.
- Watchdog:
  - Counts in BUSY while owner stb=1 and wbs_ack_i, wbs_err_i, wbs_rty_i are all 0.
  - Clears to 0 on any termination, on stb=0, and on leaving BUSY.
  - When wd_cnt==TIMEOUT-1 and the count condition still holds, next state is TOUT.
  - Counter saturation is never reached.
- TOUT (exactly 1 cycle):
  - wbs_cyc_o=wbs_stb_o=0 (slave access aborted).
  - Owner err_o=1; ack_o=rty_o=0. tout_o=1. wd_cnt=0.
  - Next state: BUSY if owner cyc=1, otherwise IDLE with last_owner=owner.
  - A late slave ack arriving during TOUT is dropped.
- Simultaneous events:
  - A termination on the same cycle the counter would fire has priority; no timeout occurs.
  - Owner cyc dropping during TOUT is still acknowledged with err; then IDLE.
- Outside BUSY: wbs_cyc_o and wbs_stb_o are forced 0; wbs_adr_o/dat_o/sel_o/we_o/cti_o/bte_o are 0.

Test Plan:
1. Reset, then m0 single read at 0x1000, slave acks 2 cycles after stb: wbs_cyc_o rises 1 cycle after m0 cyc, wbm0_ack_o matches wbs_ack_i timing, wbm0_dat_o=wbs_dat_i, m1 sees no ack.
2. m0 and m1 raise cyc on the same cycle after reset: m0 granted first; after m0 drops cyc, one idle cycle, then m1 granted. Repeat contention: m0 is granted after m1 (alternation).
3. m1 4-beat burst (cti 010,010,010,111) while m0 requests: m1 keeps owner_o=1 for all 4 beats; m0 is granted only after m1 cyc=0.
4. TIMEOUT=8, slave never acks m0 stb: after 8 stalled cycles, wbs_stb_o=0 for 1 cycle, wbm0_err_o=1 and tout_o=1 for 1 cycle; next beat proceeds normally.
5. Slave acks on the exact cycle wd_cnt==TIMEOUT-1: normal ack, no err, tout_o stays 0.
6. wb_rst_i pulsed mid-BUSY with stb pending: next cycle busy_o=0, wbs_cyc_o=0, no ack/err to any master, and the next contention is granted to m0.

Source files
------------

// File: rtl/wb_io_arbiter.sv
// ---------------------------------------------------------------------------
// wb_io_arbiter
//
// Purpose:
//   Shares one Wishbone slave port (the IO interconnect) between two masters,
//   m0 (CPU IO) and m1 (DMA / secondary). The grant goes round-robin and is
//   held for the owner's whole cycle. The owner's request is forwarded to the
//   slave port, and the slave's response is routed back to the owner only.
//   A watchdog ends a stalled access with err, so a dead or unmapped
//   peripheral cannot lock the bus.
//
// Ports:
//   wb_clk_i, wb_rst_i         clock, synchronous active-high reset
//   wbmN_*_i  (N = 0,1)        master request: adr, dat, sel, we, cyc, stb,
//                              cti, bte
//   wbmN_dat_o                 read data (slave data fanned out to both)
//   wbmN_ack_o/err_o/rty_o     terminations, driven to the owner only
//   wbs_*_o                    request forwarded to the interconnect mux
//   wbs_dat_i, wbs_ack_i,
//   wbs_err_i, wbs_rty_i       response from the interconnect mux
//   owner_o                    current owner index, valid while busy_o = 1
//   busy_o                     a grant is active
//   tout_o                     one-cycle pulse when the watchdog fires
// ---------------------------------------------------------------------------
module wb_io_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,

  input  logic [31:0] wbm0_adr_i,
  input  logic [31:0] wbm0_dat_i,
  input  logic [3:0]  wbm0_sel_i,
  input  logic        wbm0_we_i,
  input  logic        wbm0_cyc_i,
  input  logic        wbm0_stb_i,
  input  logic [2:0]  wbm0_cti_i,
  input  logic [1:0]  wbm0_bte_i,
  output logic [31:0] wbm0_dat_o,
  output logic        wbm0_ack_o,
  output logic        wbm0_err_o,
  output logic        wbm0_rty_o,

  input  logic [31:0] wbm1_adr_i,
  input  logic [31:0] wbm1_dat_i,
  input  logic [3:0]  wbm1_sel_i,
  input  logic        wbm1_we_i,
  input  logic        wbm1_cyc_i,
  input  logic        wbm1_stb_i,
  input  logic [2:0]  wbm1_cti_i,
  input  logic [1:0]  wbm1_bte_i,
  output logic [31:0] wbm1_dat_o,
  output logic        wbm1_ack_o,
  output logic        wbm1_err_o,
  output logic        wbm1_rty_o,

  output logic [31:0] wbs_adr_o,
  output logic [31:0] wbs_dat_o,
  output logic [3:0]  wbs_sel_o,
  output logic        wbs_we_o,
  output logic        wbs_cyc_o,
  output logic        wbs_stb_o,
  output logic [2:0]  wbs_cti_o,
  output logic [1:0]  wbs_bte_o,
  input  logic [31:0] wbs_dat_i,
  input  logic        wbs_ack_i,
  input  logic        wbs_err_i,
  input  logic        wbs_rty_i,

  output logic        owner_o,
  output logic        busy_o,
  output logic        tout_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_TOUT = 2'd2;

  // Last value the watchdog may reach before a still-stalled access is killed.
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_owner_q, last_owner_d;
  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;

  logic own_cyc, own_stb, term, stall, in_busy, in_tout;

  assign own_cyc = owner_q ? wbm1_cyc_i : wbm0_cyc_i;
  assign own_stb = owner_q ? wbm1_stb_i : wbm0_stb_i;
  assign term    = wbs_ack_i | wbs_err_i | wbs_rty_i;
  assign stall   = own_stb & ~term;
  assign in_busy = (state_q == ST_BUSY);
  assign in_tout = (state_q == ST_TOUT);

  // Next-state logic. The watchdog defaults to zero, so it clears on every
  // path except an ongoing stall in BUSY. A termination in the same cycle the
  // counter would fire removes the stall, so it wins over the timeout.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    wd_cnt_d     = '0;
    case (state_q)
      ST_IDLE: begin
        if (wbm0_cyc_i && wbm1_cyc_i) begin
          state_d = ST_BUSY;
          owner_d = ~last_owner_q;
        end else if (wbm0_cyc_i) begin
          state_d = ST_BUSY;
          owner_d = 1'b0;
        end else if (wbm1_cyc_i) begin
          state_d = ST_BUSY;
          owner_d = 1'b1;
        end
      end
      ST_BUSY: begin
        if (!own_cyc) begin
          state_d      = ST_IDLE;
          last_owner_d = owner_q;
        end else if (stall) begin
          if (wd_cnt_q == WD_LAST) begin
            state_d = ST_TOUT;
          end else begin
            wd_cnt_d = wd_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_TOUT: begin
        if (own_cyc) begin
          state_d = ST_BUSY;
        end else begin
          state_d      = ST_IDLE;
          last_owner_d = owner_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers. last_owner resets to 1 so the first contention goes to m0.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      wd_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      wd_cnt_q     <= wd_cnt_d;
    end
  end

  // Request path: only BUSY forwards anything. TOUT drops cyc/stb, which is
  // what aborts the hung slave access.
  assign wbs_adr_o = in_busy ? (owner_q ? wbm1_adr_i : wbm0_adr_i) : '0;
  assign wbs_dat_o = in_busy ? (owner_q ? wbm1_dat_i : wbm0_dat_i) : '0;
  assign wbs_sel_o = in_busy ? (owner_q ? wbm1_sel_i : wbm0_sel_i) : '0;
  assign wbs_we_o  = in_busy & (owner_q ? wbm1_we_i : wbm0_we_i);
  assign wbs_cti_o = in_busy ? (owner_q ? wbm1_cti_i : wbm0_cti_i) : '0;
  assign wbs_bte_o = in_busy ? (owner_q ? wbm1_bte_i : wbm0_bte_i) : '0;
  assign wbs_cyc_o = in_busy & own_cyc;
  assign wbs_stb_o = in_busy & own_stb;

  // Response path: combinational pass-through to the owner so beats take no
  // extra cycle. During TOUT the owner sees err only; a late slave ack is lost.
  assign wbm0_dat_o = wbs_dat_i;
  assign wbm1_dat_o = wbs_dat_i;
  assign wbm0_ack_o = ~owner_q & in_busy & wbs_ack_i;
  assign wbm0_err_o = ~owner_q & ((in_busy & wbs_err_i) | in_tout);
  assign wbm0_rty_o = ~owner_q & in_busy & wbs_rty_i;
  assign wbm1_ack_o = owner_q & in_busy & wbs_ack_i;
  assign wbm1_err_o = owner_q & ((in_busy & wbs_err_i) | in_tout);
  assign wbm1_rty_o = owner_q & in_busy & wbs_rty_i;

  assign owner_o = owner_q;
  assign busy_o  = (state_q != ST_IDLE);
  assign tout_o  = in_tout;

endmodule

// File: tb/tb_wb_io_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_io_arbiter
//
// Directed bench for wb_io_arbiter built with TIMEOUT = 8. The main process
// drives masters and a hand-scripted slave. Every cycle in which a
// termination or a timeout is expected gets one entry in expQ. The monitor
// pops an entry for each cycle in which the DUT presents a termination or
// tout_o, and compares it with what the DUT shows. Grant state is checked
// directly with checkOutput.
// ---------------------------------------------------------------------------
module tb_wb_io_arbiter;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;

  logic [31:0] wbm0_adr_i = '0, wbm0_dat_i = '0;
  logic [3:0]  wbm0_sel_i = '0;
  logic        wbm0_we_i = 1'b0, wbm0_cyc_i = 1'b0, wbm0_stb_i = 1'b0;
  logic [2:0]  wbm0_cti_i = '0;
  logic [1:0]  wbm0_bte_i = '0;
  logic [31:0] wbm0_dat_o;
  logic        wbm0_ack_o, wbm0_err_o, wbm0_rty_o;

  logic [31:0] wbm1_adr_i = '0, wbm1_dat_i = '0;
  logic [3:0]  wbm1_sel_i = '0;
  logic        wbm1_we_i = 1'b0, wbm1_cyc_i = 1'b0, wbm1_stb_i = 1'b0;
  logic [2:0]  wbm1_cti_i = '0;
  logic [1:0]  wbm1_bte_i = '0;
  logic [31:0] wbm1_dat_o;
  logic        wbm1_ack_o, wbm1_err_o, wbm1_rty_o;

  logic [31:0] wbs_adr_o, wbs_dat_o;
  logic [3:0]  wbs_sel_o;
  logic        wbs_we_o, wbs_cyc_o, wbs_stb_o;
  logic [2:0]  wbs_cti_o;
  logic [1:0]  wbs_bte_o;
  logic [31:0] wbs_dat_i = '0;
  logic        wbs_ack_i = 1'b0, wbs_err_i = 1'b0, wbs_rty_i = 1'b0;

  logic        owner_o, busy_o, tout_o;

  // One observed/expected termination event:
  // term = {m0 ack, m0 err, m0 rty, m1 ack, m1 err, m1 rty}
  typedef struct packed {
    logic        owner;
    logic [5:0]  term;
    logic        tout;
    logic [31:0] rdat;
    logic [31:0] adr;
    logic [31:0] wdat;
  } obs_t;

  obs_t expQ[$];
  obs_t monAct, monExp;
  int   checks = 0;
  int   errors = 0;
  logic monEn  = 1'b0;

  wb_io_arbiter #(.TIMEOUT(8)) dut (
    .wb_clk_i   (wb_clk_i),   .wb_rst_i   (wb_rst_i),
    .wbm0_adr_i (wbm0_adr_i), .wbm0_dat_i (wbm0_dat_i), .wbm0_sel_i (wbm0_sel_i),
    .wbm0_we_i  (wbm0_we_i),  .wbm0_cyc_i (wbm0_cyc_i), .wbm0_stb_i (wbm0_stb_i),
    .wbm0_cti_i (wbm0_cti_i), .wbm0_bte_i (wbm0_bte_i), .wbm0_dat_o (wbm0_dat_o),
    .wbm0_ack_o (wbm0_ack_o), .wbm0_err_o (wbm0_err_o), .wbm0_rty_o (wbm0_rty_o),
    .wbm1_adr_i (wbm1_adr_i), .wbm1_dat_i (wbm1_dat_i), .wbm1_sel_i (wbm1_sel_i),
    .wbm1_we_i  (wbm1_we_i),  .wbm1_cyc_i (wbm1_cyc_i), .wbm1_stb_i (wbm1_stb_i),
    .wbm1_cti_i (wbm1_cti_i), .wbm1_bte_i (wbm1_bte_i), .wbm1_dat_o (wbm1_dat_o),
    .wbm1_ack_o (wbm1_ack_o), .wbm1_err_o (wbm1_err_o), .wbm1_rty_o (wbm1_rty_o),
    .wbs_adr_o  (wbs_adr_o),  .wbs_dat_o  (wbs_dat_o),  .wbs_sel_o  (wbs_sel_o),
    .wbs_we_o   (wbs_we_o),   .wbs_cyc_o  (wbs_cyc_o),  .wbs_stb_o  (wbs_stb_o),
    .wbs_cti_o  (wbs_cti_o),  .wbs_bte_o  (wbs_bte_o),  .wbs_dat_i  (wbs_dat_i),
    .wbs_ack_i  (wbs_ack_i),  .wbs_err_i  (wbs_err_i),  .wbs_rty_i  (wbs_rty_i),
    .owner_o    (owner_o),    .busy_o     (busy_o),     .tout_o     (tout_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL simTimeout actual=running required=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  // Monitor: on every falling edge where the DUT presents a termination or a
  // timeout pulse, pop the next expected event and compare.
  always @(negedge wb_clk_i) begin
    if (monEn && (wbm0_ack_o || wbm0_err_o || wbm0_rty_o ||
                  wbm1_ack_o || wbm1_err_o || wbm1_rty_o || tout_o)) begin
      monAct = {owner_o, wbm0_ack_o, wbm0_err_o, wbm0_rty_o,
                wbm1_ack_o, wbm1_err_o, wbm1_rty_o, tout_o,
                (owner_o ? wbm1_dat_o : wbm0_dat_o), wbs_adr_o, wbs_dat_o};
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpectedTerm actual=%h required=none (t=%0t)", monAct, $time);
      end else begin
        monExp = expQ.pop_front();
        if (monAct !== monExp) begin
          errors++;
          $display("[TB] FAIL scoreboard actual=%h required=%h (t=%0t)", monAct, monExp, $time);
        end
      end
    end
  end

  // Advance to just after the next rising edge, where stimulus is driven.
  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic applyStimulus(input int m, input logic cyc, input logic stb,
                               input logic we, input logic [31:0] adr,
                               input logic [31:0] dat, input logic [2:0] cti,
                               input logic [1:0] bte);
    if (m == 0) begin
      wbm0_cyc_i = cyc; wbm0_stb_i = stb; wbm0_we_i = we; wbm0_adr_i = adr;
      wbm0_dat_i = dat; wbm0_cti_i = cti; wbm0_bte_i = bte;
      wbm0_sel_i = cyc ? 4'hF : 4'h0;
    end else begin
      wbm1_cyc_i = cyc; wbm1_stb_i = stb; wbm1_we_i = we; wbm1_adr_i = adr;
      wbm1_dat_i = dat; wbm1_cti_i = cti; wbm1_bte_i = bte;
      wbm1_sel_i = cyc ? 4'hF : 4'h0;
    end
  endtask

  task automatic setSlave(input logic ack, input logic err, input logic rty,
                          input logic [31:0] rdat);
    wbs_ack_i = ack; wbs_err_i = err; wbs_rty_i = rty; wbs_dat_i = rdat;
  endtask

  task automatic pushExp(input logic owner, input logic [5:0] term,
                         input logic tout, input logic [31:0] rdat,
                         input logic [31:0] adr, input logic [31:0] wdat);
    obs_t e;
    e = {owner, term, tout, rdat, adr, wdat};
    expQ.push_back(e);
  endtask

  // Snapshot of grant/request state; owner only counts while busy.
  function automatic logic [63:0] snap();
    return {17'b0, busy_o, owner_o & busy_o, wbs_cyc_o, wbs_stb_o, wbs_we_o,
            tout_o, wbs_sel_o, wbs_cti_o, wbs_bte_o, wbs_adr_o};
  endfunction

  function automatic logic [63:0] mk(input logic busy, input logic owner,
                                     input logic cyc, input logic stb,
                                     input logic we, input logic tout,
                                     input logic [3:0] sel, input logic [2:0] cti,
                                     input logic [1:0] bte, input logic [31:0] adr);
    return {17'b0, busy, owner, cyc, stb, we, tout, sel, cti, bte, adr};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] expected);
    logic [63:0] act;
    @(negedge wb_clk_i);
    act = snap();
    checks++;
    if (act !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, expected);
    end
  endtask

  task automatic doReset();
    wb_rst_i = 1'b1;
    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 3'b000, 2'b00);
    applyStimulus(1, 0, 0, 0, 32'h0, 32'h0, 3'b000, 2'b00);
    setSlave(0, 0, 0, 32'h0);
    tick();
    tick();
    checkOutput("resetState", mk(0, 0, 0, 0, 0, 0, 4'h0, 3'b000, 2'b00, 32'h0));
    tick();
    wb_rst_i = 1'b0;
    monEn    = 1'b1;
  endtask

  localparam logic [5:0] M0ACK = 6'b100000;
  localparam logic [5:0] M0ERR = 6'b010000;
  localparam logic [5:0] M1ACK = 6'b000100;

  initial begin
    $display("[TB] start");

    // 1: m0 single read, slave acks two cycles after stb.
    doReset();
    applyStimulus(0, 1, 1, 0, 32'h1000, 32'h0, 3'b000, 2'b00);
    checkOutput("t1Latency", mk(0, 0, 0, 0, 0, 0, 4'h0, 3'b000, 2'b00, 32'h0));
    tick();
    checkOutput("t1Grant", mk(1, 0, 1, 1, 0, 0, 4'hF, 3'b000, 2'b00, 32'h1000));
    tick();
    tick();
    setSlave(1, 0, 0, 32'hCAFE_F00D);
    pushExp(0, M0ACK, 0, 32'hCAFE_F00D, 32'h1000, 32'h0);
    tick();
    setSlave(0, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 3'b000, 2'b00);
    tick();
    checkOutput("t1Idle", mk(0, 0, 0, 0, 0, 0, 4'h0, 3'b000, 2'b00, 32'h0));

    // 2: contention after reset goes to m0, then m1; repeat alternates.
    doReset();
    applyStimulus(0, 1, 1, 0, 32'h2000, 32'h0, 3'b000, 2'b00);
    applyStimulus(1, 1, 1, 1, 32'h2100, 32'h1111_2222, 3'b000, 2'b00);
    tick();
    setSlave(1, 0, 0, 32'h0000_A5A5);
    pushExp(0, M0ACK, 0, 32'h0000_A5A5, 32'h2000, 32'h0);
    checkOutput("t2GrantM0", mk(1, 0, 1, 1, 0, 0, 4'hF, 3'b000, 2'b00, 32'h2000));
    tick();
    setSlave(0, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 3'b000, 2'b00);
    tick();
    checkOutput("t2IdleGap", mk(0, 0, 0, 0, 0, 0, 4'h0, 3'b000, 2'b00, 32'h0));
    tick();
    setSlave(1, 0, 0, 32'h5A5A_0000);
    pushExp(1, M1ACK, 0, 32'h5A5A_0000, 32'h2100, 32'h1111_2222);
    checkOutput("t2GrantM1", mk(1, 1, 1, 1, 1, 0, 4'hF, 3'b000, 2'b00, 32'h2100));
    tick();
    setSlave(0, 0, 0, 32'h0);
    applyStimulus(1, 0, 0, 0, 32'h0, 32'h0, 3'b000, 2'b00);
    tick();
    applyStimulus(0, 1, 1, 0, 32'h2200, 32'h0, 3'b000, 2'b00);
    applyStimulus(1, 1, 1, 0, 32'h2300, 32'h0, 3'b000, 2'b00);
    tick();
    setSlave(1, 0, 0, 32'h0000_2222);
    pushExp(0, M0ACK, 0, 32'h0000_2222, 32'h2200, 32'h0);
    checkOutput("t2RepeatM0", mk(1, 0, 1, 1, 0, 0, 4'hF, 3'b000, 2'b00, 32'h2200));
    tick();
    setSlave(0, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 3'b000, 2'b00);
    tick();
    tick();
    setSlave(1, 0, 0, 32'h0000_2323);
    pushExp(1, M1ACK, 0, 32'h0000_2323, 32'h2300, 32'h0);
    checkOutput("t2RepeatM1", mk(1, 1, 1, 1, 0, 0, 4'hF, 3'b000, 2'b00, 32'h2300));
    tick();
    setSlave(0, 0, 0, 32'h0);
    applyStimulus(1, 0, 0, 0, 32'h0, 32'h0, 3'b000, 2'b00);
    tick();

    // 3: m1 4-beat burst is not preempted by a pending m0 request.
    applyStimulus(1, 1, 1, 1, 32'h3000, 32'hB000_0000, 3'b010, 2'b01);
    tick();
    applyStimulus(0, 1, 1, 0, 32'h3100, 32'h0, 3'b000, 2'b00);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1, 1, 1, 32'(32'h3000 + 4 * i), 32'(32'hB000_0000 + i),
                    (i == 3) ? 3'b111 : 3'b010, 2'b01);
      setSlave(1, 0, 0, 32'(32'h100 + i));
      pushExp(1, M1ACK, 0, 32'(32'h100 + i), 32'(32'h3000 + 4 * i),
              32'(32'hB000_0000 + i));
      if (i == 0)
        checkOutput("t3Burst", mk(1, 1, 1, 1, 1, 0, 4'hF, 3'b010, 2'b01, 32'h3000));
      tick();
    end
    setSlave(0, 0, 0, 32'h0);
    applyStimulus(1, 0, 0, 0, 32'h0, 32'h0, 3'b000, 2'b00);
    tick();
    checkOutput("t3Idle", mk(0, 0, 0, 0, 0, 0, 4'h0, 3'b000, 2'b00, 32'h0));
    tick();
    setSlave(1, 0, 0, 32'h0000_3131);
    pushExp(0, M0ACK, 0, 32'h0000_3131, 32'h3100, 32'h0);
    checkOutput("t3GrantM0", mk(1, 0, 1, 1, 0, 0, 4'hF, 3'b000, 2'b00, 32'h3100));
    tick();
    setSlave(0, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 3'b000, 2'b00);
    tick();

    // 4: slave never acks; after 8 stalled cycles the access is killed.
    applyStimulus(0, 1, 1, 0, 32'h4000, 32'h0, 3'b000, 2'b00);
    tick();
    for (int i = 0; i < 8; i++) tick();
    setSlave(1, 0, 0, 32'hDEAD_0001);
    pushExp(0, M0ERR, 1, 32'hDEAD_0001, 32'h0, 32'h0);
    checkOutput("t4Abort", mk(1, 0, 0, 0, 0, 1, 4'h0, 3'b000, 2'b00, 32'h0));
    tick();
    setSlave(1, 0, 0, 32'hDEAD_0002);
    pushExp(0, M0ACK, 0, 32'hDEAD_0002, 32'h4000, 32'h0);
    tick();
    setSlave(0, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 3'b000, 2'b00);
    tick();

    // 5: ack lands on the cycle the watchdog would fire; no timeout.
    applyStimulus(0, 1, 1, 0, 32'h5000, 32'h0, 3'b000, 2'b00);
    tick();
    for (int i = 0; i < 7; i++) tick();
    setSlave(1, 0, 0, 32'h0000_0055);
    pushExp(0, M0ACK, 0, 32'h0000_0055, 32'h5000, 32'h0);
    tick();
    setSlave(0, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 0, 32'h5000, 32'h0, 3'b000, 2'b00);
    checkOutput("t5NoTout", mk(1, 0, 0, 0, 0, 0, 4'h0, 3'b000, 2'b00, 32'h5000));
    tick();

    // 6: reset mid-access abandons it silently and restores m0 priority.
    applyStimulus(0, 1, 1, 0, 32'h6000, 32'h0, 3'b000, 2'b00);
    tick();
    tick();
    tick();
    wb_rst_i = 1'b1;
    tick();
    wb_rst_i = 1'b0;
    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 3'b000, 2'b00);
    checkOutput("t6AfterReset", mk(0, 0, 0, 0, 0, 0, 4'h0, 3'b000, 2'b00, 32'h0));
    tick();
    applyStimulus(0, 1, 1, 0, 32'h6100, 32'h0, 3'b000, 2'b00);
    applyStimulus(1, 1, 1, 0, 32'h6200, 32'h0, 3'b000, 2'b00);
    tick();
    setSlave(1, 0, 0, 32'h0000_6161);
    pushExp(0, M0ACK, 0, 32'h0000_6161, 32'h6100, 32'h0);
    checkOutput("t6GrantM0", mk(1, 0, 1, 1, 0, 0, 4'hF, 3'b000, 2'b00, 32'h6100));
    tick();
    setSlave(0, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 3'b000, 2'b00);
    applyStimulus(1, 0, 0, 0, 32'h0, 32'h0, 3'b000, 2'b00);
    tick();
    tick();

    // Every expected termination must have been seen.
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL pendingExpected actual=%0d required=0", expQ.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
